// File: rtl/operand_result_pipe.sv
// operand_result_pipe: RA2/B select into S1, Result select into S2.
// Valid/ready flow, RAW stall; S2->B forwarding when OPERAND_FWD_EN.
// Ports: clk, rst_n (async low); in_valid/in_ready issue handshake;
// Src2, RDst3, WE, ALUSrc2, ALUorM issue fields; RA2 -> RD2 regfile read;
// B, ExValid (S1); R, ReadData from execute; Result, WbAddr, WbEn,
// out_valid/out_ready writeback handshake (S2).
module operand_result_pipe #(
  parameter int N  = 8,
  parameter int RW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  Src2,
  input  logic [RW-1:0] RDst3,
  input  logic          WE,
  input  logic          ALUSrc2,
  input  logic          ALUorM,
  output logic [RW-1:0] RA2,
  input  logic [N-1:0]  RD2,
  output logic [N-1:0]  B,
  output logic          ExValid,
  input  logic [N-1:0]  R,
  input  logic [N-1:0]  ReadData,
  output logic [N-1:0]  Result,
  output logic [RW-1:0] WbAddr,
  output logic          WbEn,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [N-1:0]  r_b;
  logic          r_ex_valid;
  logic [RW-1:0] r_dst_s1;
  logic          r_we_s1;
  logic          r_aluorm_s1;
  logic [N-1:0]  r_result;
  logic [RW-1:0] r_wb_addr;
  logic          r_wb_en;
  logic          r_out_valid;

  logic [RW-1:0] w_ra2;
  logic          w_s2_adv;
  logic          w_haz_s1;
  logic          w_haz_s2;
  logic          w_stall;
  logic [N-1:0]  w_operand;
  logic          w_in_ready;
  logic          w_accept;

  assign w_ra2 = WE ? RDst3 : Src2[N-1:N-RW];

  assign w_s2_adv = !r_out_valid || out_ready;

  // Immediate operands never read the register file, so no hazard.
  assign w_haz_s1 = !ALUSrc2 && r_ex_valid && r_we_s1
                    && (r_dst_s1 == w_ra2);
  assign w_haz_s2 = !ALUSrc2 && r_out_valid && r_wb_en
                    && (r_wb_addr == w_ra2);

`ifdef OPERAND_FWD_EN
  // S2 value is final even when held by back-pressure.
  assign w_operand = w_haz_s2 ? r_result : RD2;
  assign w_stall   = w_haz_s1;
`else
  assign w_operand = RD2;
  assign w_stall   = w_haz_s1 || w_haz_s2;
`endif

  assign w_in_ready = (!r_ex_valid || w_s2_adv) && !w_stall;
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b         <= '0;
      r_ex_valid  <= 1'b0;
      r_dst_s1    <= '0;
      r_we_s1     <= 1'b0;
      r_aluorm_s1 <= 1'b0;
    end else if (w_accept) begin
      r_b         <= ALUSrc2 ? Src2 : w_operand;
      r_ex_valid  <= 1'b1;
      r_dst_s1    <= RDst3;
      r_we_s1     <= WE;
      r_aluorm_s1 <= ALUorM;
    end else if (w_s2_adv) begin
      r_ex_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_wb_addr   <= '0;
      r_wb_en     <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_ex_valid;
      r_wb_en     <= r_ex_valid && r_we_s1;
      if (r_ex_valid) begin
        r_result  <= r_aluorm_s1 ? ReadData : R;
        r_wb_addr <= r_dst_s1;
      end
    end
  end

  assign RA2       = w_ra2;
  assign in_ready  = w_in_ready;
  assign B         = r_b;
  assign ExValid   = r_ex_valid;
  assign Result    = r_result;
  assign WbAddr    = r_wb_addr;
  assign WbEn      = r_wb_en;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_operand_result_pipe.sv
// tb_operand_result_pipe: scoreboard bench for operand_result_pipe.
// Bench models regfile, ALU (B+1) and memory (nibble swap ^ 0x7F).
module tb_operand_result_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] Src2;
  logic [1:0] RDst3;
  logic       WE;
  logic       ALUSrc2;
  logic       ALUorM;
  logic [1:0] RA2;
  logic [7:0] RD2;
  logic [7:0] B;
  logic       ExValid;
  logic [7:0] R;
  logic [7:0] ReadData;
  logic [7:0] Result;
  logic [1:0] WbAddr;
  logic       WbEn;
  logic       out_valid;
  logic       out_ready;

  typedef struct packed {
    logic [7:0] r;
    logic [1:0] a;
    logic       e;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rf[4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] arch[4];
  int         n_chk = 0;
  int         n_fail = 0;

  operand_result_pipe #(.N(8), .RW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Src2(Src2), .RDst3(RDst3), .WE(WE),
    .ALUSrc2(ALUSrc2), .ALUorM(ALUorM),
    .RA2(RA2), .RD2(RD2), .B(B), .ExValid(ExValid),
    .R(R), .ReadData(ReadData), .Result(Result),
    .WbAddr(WbAddr), .WbEn(WbEn),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [7:0] b);
    return {b[3:0], b[7:4]} ^ 8'h7F;
  endfunction

  assign RD2      = rf[RA2];
  assign R        = B + 8'd1;
  assign ReadData = memf(B);

  always @(posedge clk)
    if (rst_n && out_valid && out_ready && WbEn)
      rf[WbAddr] <= Result;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_Result", Result, e.r);
        chk("sb_WbAddr", WbAddr, e.a);
        chk("sb_WbEn", WbEn, e.e);
      end
    end
  end

  task automatic issue(input logic [7:0] s,
                       input logic [1:0] d,
                       input logic w,
                       input logic as,
                       input logic am,
                       output int waits);
    logic [1:0] ra;
    logic [7:0] bx;
    exp_t       e;
    bit         ok;
    Src2 = s; RDst3 = d; WE = w;
    ALUSrc2 = as; ALUorM = am;
    in_valid = 1'b1;
    waits = 0; ok = 0; bx = '0;
    ra = w ? d : s[7:6];
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else waits++;
      if (ok) begin
        bx = as ? s : arch[ra];
        e.r = am ? memf(bx) : bx + 8'd1;
        e.a = d;
        e.e = w;
        sb.push_back(e);
        if (w) arch[d] = e.r;
      end
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    chk("issue_timeout", ok, 1);
    if (ok) begin
      chk("B", B, bx);
      chk("ExValid", ExValid, 1);
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 50) begin
      @(posedge clk);
      i++;
    end
    chk("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    logic [7:0] hold;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Src2 = '0; RDst3 = '0; WE = 1'b0;
    ALUSrc2 = 1'b0; ALUorM = 1'b0;
    for (int i = 0; i < 4; i++) arch[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ExValid", ExValid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_B", B, 0);
    chk("rst_Result", Result, 0);
    chk("rst_WbAddr", WbAddr, 0);
    chk("rst_WbEn", WbEn, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1);

    issue(8'h5A, 2'd1, 1'b1, 1'b1, 1'b0, w);
    chk("byp_B", B, 8'h5A);
    @(posedge clk);
    #1;
    chk("byp_Result", Result, 8'h5B);
    chk("byp_WbAddr", WbAddr, 1);
    chk("byp_WbEn", WbEn, 1);
    chk("byp_out_valid", out_valid, 1);
    drain();

    WE = 1'b0; Src2 = 8'h80; #1;
    chk("ra2_field", RA2, 2);
    WE = 1'b1; RDst3 = 2'd3; #1;
    chk("ra2_dst", RA2, 3);

    issue(8'h00, 2'd2, 1'b1, 1'b1, 1'b1, w);
    @(posedge clk);
    #1;
    chk("mem_Result", Result, 8'h7F);
    drain();

    issue(8'h10, 2'd3, 1'b1, 1'b1, 1'b0, w);
    issue(8'hC0, 2'd0, 1'b0, 1'b0, 1'b0, w);
`ifdef OPERAND_FWD_EN
    chk("haz_waits", w, 1);
`else
    chk("haz_waits", w, 2);
`endif
    chk("haz_B", B, 8'h11);
    drain();

    for (int i = 0; i < 4; i++) begin
      issue(8'h20 + 8'(i), 2'(i), 1'b1, 1'b1, 1'b0, w);
      chk("thru_waits", w, 0);
    end
    drain();

    out_ready = 1'b0;
    issue(8'h44, 2'd1, 1'b1, 1'b1, 1'b0, w);
    issue(8'h66, 2'd3, 1'b1, 1'b1, 1'b1, w);
    hold = 8'h45;
    for (int i = 0; i < 3; i++) begin
      chk("bp_Result", Result, hold);
      chk("bp_ExValid", ExValid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    issue(8'h90, 2'd0, 1'b1, 1'b1, 1'b0, w);
    issue(8'hA0, 2'd2, 1'b1, 1'b1, 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_ExValid", ExValid, 0);
    chk("mrst_WbEn", WbEn, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_rf0", rf[0], 8'h21);
    chk("mrst_rf2", rf[2], 8'h23);
    sb.delete();
    for (int i = 0; i < 4; i++) arch[i] = rf[i];
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(8'h40, 2'd0, 1'b0, 1'b0, 1'b0, w);
    chk("post_B", B, 8'h45);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/operand_result_pipe.md
Name: operand_result_pipe

Overview:
- Two-stage, parametrised successor to the lab datapath select muxes (RA2 / B / Result).
- Selects the register-file read address and the ALU operand B, and registers B into an execute stage (S1).
- Selects and registers Result (ALU result or memory data) into a writeback stage (S2).
- Adds valid/ready flow control, RAW hazard detection, and optional S2->B forwarding.

Parameters:
- N, 8: data width of Src2, RD2, B, R, ReadData, Result.
- RW, 2: register address width; the RA field is Src2[N-1:N-RW]. Requires RW <= N.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  issue request
- in_ready  out  1  issue accepted when in_valid && in_ready
- Src2  in  N  immediate / address-field source
- RDst3  in  RW  destination register address
- WE  in  1  0: RA2 from Src2 field; 1: RA2 = RDst3; also marks the instruction as writing back
- ALUSrc2  in  1  0: B from register (RD2 or forwarded); 1: B = Src2
- ALUorM  in  1  0: Result = R; 1: Result = ReadData
- RA2  out  RW  combinational register-file read address
- RD2  in  N  register-file data for RA2, same cycle
- B  out  N  registered operand (S1)
- ExValid  out  1  S1 holds a valid instruction
- R  in  N  ALU result computed from B, valid while ExValid
- ReadData  in  N  memory data, valid while ExValid
- Result  out  N  registered result (S2)
- WbAddr  out  RW  S2 destination address
- WbEn  out  1  S2 valid && S2 WE
- out_valid  out  1  S2 holds a valid result
- out_ready  in  1  consumer accepts S2; the register file writes when out_valid && out_ready && WbEn

Behaviour:
- Reset, asynchronous and active-low, applies to all state:
  - ExValid = 0, out_valid = 0.
  - B, Result, WbAddr, WbEn = 0.
  - Stored S1 fields (dst, WE, ALUorM) = 0.
- Reset asserted mid-operation discards all in-flight instructions. There is no writeback while reset is asserted.
- RA2 is purely combinational: RA2 = WE ? RDst3 : Src2[N-1:N-RW]. It is valid whenever inputs are stable, independent of in_valid.
- Advance conditions:
  - s2_adv = !out_valid || out_ready.
  - S1 -> S2 transfer when ExValid && s2_adv.
  - S2 load: Result <= ALUorM_s1 ? ReadData : R; WbAddr <= dst_s1; WbEn <= WE_s1.
  - When s2_adv is true and ExValid = 0, out_valid goes to 0.
- Hazards (evaluated only when ALUSrc2 = 0):
  - haz_s1 = ExValid && WE_s1 && dst_s1 == RA2. Always stalls; checked against current registered S1 contents, so the cost is a one-cycle bubble.
  - haz_s2 = out_valid && WbEn && WbAddr == RA2. Handled per the Optional Feature.
- in_ready = (!ExValid || s2_adv) && !stall. Combinational, no dependence on in_valid.
- On accept:
  - B <= ALUSrc2 ? Src2 : operand.
  - dst_s1 <= RDst3; WE_s1 <= WE; ALUorM_s1 <= ALUorM; ExValid <= 1.
- If S1 drains with no accept, ExValid <= 0 and B holds its value.
- Under back-pressure (out_ready = 0, out_valid = 1): S2 holds; S1 holds if full; in_ready = 0.
- Latency: accept -> B visible 1 cycle; accept -> Result visible 2 cycles (no stall).
- Throughput: 1 instruction per cycle with no hazards and out_ready = 1.
- All selection is bit-exact. No arithmetic and no sign extension inside the block.

Optional Feature:
- Macro: OPERAND_FWD_EN
- Defined:
  - operand = haz_s2 ? Result : RD2.
  - stall = haz_s1.
  - A dependent instruction issues while its producer sits in S2, even under back-pressure.
- Undefined:
  - operand = RD2.
  - stall = haz_s1 || haz_s2.
  - The consumer waits until the producer retires (out_valid && out_ready), then reads the updated RD2.

Test Plan:
- Reset and bypass: reset, then issue ALUSrc2=1, Src2=0x5A, WE=1, RDst3=1, ALUorM=0, R=0x5B. Require B=0x5A and ExValid=1 at +1 cycle; Result=0x5B, WbAddr=1, WbEn=1, out_valid=1 at +2.
- RA2 select: WE=0, Src2=0x80 -> RA2=2; WE=1, RDst3=3 -> RA2=3. Both in the same cycle, in_valid=0.
- Memory select: ALUorM=1, ReadData=0x7F, R=0x01 -> Result=0x7F.
- Hazard:
  - Setup: A writes r3 (R=0x11). B follows immediately with WE=0, Src2=0xC0, ALUSrc2=0, RD2=0x00.
  - Common to both builds: in_ready=0 for 1 cycle (haz_s1).
  - OPERAND_FWD_EN defined: B issues next cycle with B output = 0x11.
  - OPERAND_FWD_EN undefined: in_ready stays 0 until A retires; B then issues with the RD2 value.
- Back-pressure: out_ready=0 for 3 cycles with 2 instructions issued. Result stays constant, ExValid=1, in_ready=0; both results retire in order once out_ready=1.
- Reset mid-flight: assert rst_n=0 with S1 and S2 full. out_valid, ExValid, and WbEn go to 0 immediately (asynchronously); no writeback handshake occurs.
